// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction fetch front end. Holds the program counter, drives it to a
// combinational instruction memory, captures the returned word into a small
// FIFO and presents {pc, inst, fault} to decode over a valid/ready handshake.
// A misaligned pc pushes one fault entry carrying NOP_INST and then halts
// fetch until a redirect arrives.
//
// Optional feature: define FETCH_PERF_EN to add the perf_fetch_cnt and
// perf_stall_cnt ports and counters.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   imem_pc         address to instruction memory (registered pc)
//   imem_inst       word returned combinationally for imem_pc
//   redirect_valid  flush the FIFO and load redirect_pc
//   redirect_pc     redirect target
//   out_valid       FIFO head valid
//   out_ready       decode accepts head
//   out_inst        head instruction
//   out_pc          head pc
//   out_fault       head is a misaligned-fetch fault
//   perf_fetch_cnt  pushes into the FIFO        (FETCH_PERF_EN only)
//   perf_stall_cnt  RUN cycles blocked by full  (FETCH_PERF_EN only)
module fetch_unit #(
  parameter int                     PC_WIDTH   = 32,
  parameter int                     INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC   = 32'h0000_0000,
  parameter int                     FIFO_DEPTH = 2,
  parameter logic [INST_WIDTH-1:0]  NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PC_WIDTH-1:0]   imem_pc,
  input  logic [INST_WIDTH-1:0] imem_inst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic                  out_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // Entry storage is written only on push and never needs reset: the head
  // outputs are masked while the FIFO is empty.
  logic [PC_WIDTH-1:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst_q [FIFO_DEPTH];
  logic                  fifo_fault_q[FIFO_DEPTH];

  logic                  pop, can_push, push, stall, aligned;
  logic [INST_WIDTH-1:0] ent_inst_d;
  logic                  ent_fault_d;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign can_push  = (count_q < FULL_CNT) | pop;
  assign aligned   = (pc_q[1:0] == 2'b00);
  assign push      = (state_q == ST_RUN) & ~redirect_valid & can_push;
  assign stall     = (state_q == ST_RUN) & ~redirect_valid & ~can_push;

  assign ent_inst_d  = aligned ? imem_inst : NOP_INST;
  assign ent_fault_d = ~aligned;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      // Flush drops everything, including a head being popped this cycle.
      state_d  = ST_RUN;
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (aligned) pc_d = pc_q + PC_WIDTH'(4);
        else         state_d = ST_HALT;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= pc_q;
      fifo_inst_q[wr_ptr_q]  <= ent_inst_d;
      fifo_fault_q[wr_ptr_q] <= ent_fault_d;
    end
  end

  assign imem_pc   = pc_q;
  assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]   : '0;
  assign out_inst  = out_valid ? fifo_inst_q[rd_ptr_q] : '0;
  assign out_fault = out_valid & fifo_fault_q[rd_ptr_q];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + (push  ? 32'd1 : 32'd0);
    perf_stall_d = perf_stall_q + (stall ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Instruction memory model: the word at
// byte address 4k is k, i.e. imem_inst = imem_pc >> 2.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_inst = {2'b00, imem_pc[31:2]};

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Advance one clock edge and settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across one edge, release 1ns after an edge.
  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = rdy;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    n_cmp++; if (imem_pc !== 32'h0) begin n_err++; $display("FAIL reset_imem_pc got %h want %h", imem_pc, 32'h0); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_inst !== 32'h0) begin n_err++; $display("FAIL reset_out_inst got %h want 0", out_inst); end
    n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    n_cmp++; if (out_fault !== 1'b0) begin n_err++; $display("FAIL reset_out_fault got %b want 0", out_fault); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_fetch_cnt !== 32'd0) begin n_err++; $display("FAIL reset_perf_fetch got %0d want 0", perf_fetch_cnt); end
    n_cmp++; if (perf_stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_perf_stall got %0d want 0", perf_stall_cnt); end
`endif
  endtask

  // out_ready held high: one instruction per cycle, pc 0,4,8,... inst 0,1,2,...
  task automatic test_back_to_back();
    do_reset(1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got %b want 1", k, out_valid); end
      n_cmp++; if (out_pc !== 32'(4 * k)) begin n_err++; $display("FAIL b2b_pc[%0d] got %h want %h", k, out_pc, 32'(4 * k)); end
      n_cmp++; if (out_inst !== 32'(k)) begin n_err++; $display("FAIL b2b_inst[%0d] got %h want %h", k, out_inst, 32'(k)); end
      n_cmp++; if (imem_pc !== 32'(4 * k + 4)) begin n_err++; $display("FAIL b2b_imem_pc[%0d] got %h want %h", k, imem_pc, 32'(4 * k + 4)); end
    end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_fetch_cnt !== 32'd6) begin n_err++; $display("FAIL b2b_perf_fetch got %0d want 6", perf_fetch_cnt); end
    n_cmp++; if (perf_stall_cnt !== 32'd0) begin n_err++; $display("FAIL b2b_perf_stall got %0d want 0", perf_stall_cnt); end
`endif
  endtask

  // Decode stalls 5 cycles: two entries buffer, fetch stalls at pc 8.
  task automatic test_backpressure();
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d] got %b want 1", k, out_valid); end
      n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL bp_hold_pc[%0d] got %h want 0", k, out_pc); end
      n_cmp++; if (out_inst !== 32'h0) begin n_err++; $display("FAIL bp_hold_inst[%0d] got %h want 0", k, out_inst); end
    end
    n_cmp++; if (imem_pc !== 32'h8) begin n_err++; $display("FAIL bp_imem_pc got %h want 8", imem_pc); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_stall_cnt !== 32'd3) begin n_err++; $display("FAIL bp_perf_stall got %0d want 3", perf_stall_cnt); end
    n_cmp++; if (perf_fetch_cnt !== 32'd2) begin n_err++; $display("FAIL bp_perf_fetch got %0d want 2", perf_fetch_cnt); end
`endif
    out_ready = 1'b1;
    // Head 0 pops on the next edge; following heads are 4, 8, 12.
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++; if (out_pc !== 32'(4 * k)) begin n_err++; $display("FAIL bp_release_pc[%0d] got %h want %h", k, out_pc, 32'(4 * k)); end
      n_cmp++; if (out_inst !== 32'(k)) begin n_err++; $display("FAIL bp_release_inst[%0d] got %h want %h", k, out_inst, 32'(k)); end
    end
  endtask

  // Redirect while the FIFO is full flushes it; target arrives a cycle later.
  task automatic test_redirect_full();
    do_reset(1'b0);
    step(); step(); step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush_valid got %b want 0", out_valid); end
    n_cmp++; if (imem_pc !== 32'h100) begin n_err++; $display("FAIL redir_imem_pc got %h want 100", imem_pc); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL redir_tgt_valid got %b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'h100) begin n_err++; $display("FAIL redir_tgt_pc got %h want 100", out_pc); end
    n_cmp++; if (out_inst !== 32'h40) begin n_err++; $display("FAIL redir_tgt_inst got %h want 40", out_inst); end
    n_cmp++; if (imem_pc !== 32'h104) begin n_err++; $display("FAIL redir_next_pc got %h want 104", imem_pc); end
  endtask

  // Misaligned target: one fault entry, then halted until the next redirect.
  task automatic test_misaligned();
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mis_flush_valid got %b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mis_valid got %b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'h102) begin n_err++; $display("FAIL mis_pc got %h want 102", out_pc); end
    n_cmp++; if (out_fault !== 1'b1) begin n_err++; $display("FAIL mis_fault got %b want 1", out_fault); end
    n_cmp++; if (out_inst !== 32'h13) begin n_err++; $display("FAIL mis_inst got %h want 13", out_inst); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mis_halt_valid[%0d] got %b want 0", k, out_valid); end
      n_cmp++; if (imem_pc !== 32'h102) begin n_err++; $display("FAIL mis_halt_pc[%0d] got %h want 102", k, imem_pc); end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_pc !== 32'h200) begin n_err++; $display("FAIL mis_redir_pc got %h want 200", imem_pc); end
    step();
    n_cmp++; if (out_pc !== 32'h200) begin n_err++; $display("FAIL mis_resume_pc got %h want 200", out_pc); end
    n_cmp++; if (out_inst !== 32'h80) begin n_err++; $display("FAIL mis_resume_inst got %h want 80", out_inst); end
    n_cmp++; if (out_fault !== 1'b0) begin n_err++; $display("FAIL mis_resume_fault got %b want 0", out_fault); end
    step();
    n_cmp++; if (out_pc !== 32'h204) begin n_err++; $display("FAIL mis_resume_pc2 got %h want 204", out_pc); end
  endtask

  // pc 0xFFFF_FFFC wraps to 0.
  task automatic test_wrap();
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    n_cmp++; if (out_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_head_pc got %h want fffffffc", out_pc); end
    n_cmp++; if (out_inst !== 32'h3FFF_FFFF) begin n_err++; $display("FAIL wrap_head_inst got %h want 3fffffff", out_inst); end
    n_cmp++; if (imem_pc !== 32'h0) begin n_err++; $display("FAIL wrap_imem_pc got %h want 0", imem_pc); end
    step();
    n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL wrap_next_pc got %h want 0", out_pc); end
    n_cmp++; if (out_fault !== 1'b0) begin n_err++; $display("FAIL wrap_next_fault got %b want 0", out_fault); end
  endtask

  // Asynchronous reset mid-stream clears outputs before the next edge.
  task automatic test_async_reset();
    do_reset(1'b1);
    step(); step(); step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid got %b want 1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b want 0", out_valid); end
    n_cmp++; if (imem_pc !== 32'h0) begin n_err++; $display("FAIL arst_imem_pc got %h want 0", imem_pc); end
    n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL arst_out_pc got %h want 0", out_pc); end
    n_cmp++; if (out_inst !== 32'h0) begin n_err++; $display("FAIL arst_out_inst got %h want 0", out_inst); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_fetch_cnt !== 32'd0) begin n_err++; $display("FAIL arst_perf_fetch got %0d want 0", perf_fetch_cnt); end
`endif
    #1;
    rst = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_resume_valid got %b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL arst_resume_pc got %h want 0", out_pc); end
    n_cmp++; if (imem_pc !== 32'h4) begin n_err++; $display("FAIL arst_resume_imem_pc got %h want 4", imem_pc); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_redirect_full();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end: the requesting side of the instruction memory port. Holds the program counter and drives it to the combinational instruction memory. Captures the returned word into a small FIFO and presents {pc, inst, fault} to decode over a valid/ready handshake. Sits between the branch/jump resolution logic (redirect input) and the decode stage of the pipeline.

## Interface
- PC_WIDTH, 32, program counter width
- INST_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- FIFO_DEPTH, 2, fetch buffer entries (power of two, ≥2)
- NOP_INST, 32'h0000_0013, word substituted on fault (addi x0,x0,0)

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- imem_pc  out  PC_WIDTH  address to instruction memory; equals internal pc register
- imem_inst  in  INST_WIDTH  word returned combinationally for imem_pc (same cycle)
- redirect_valid  in  1  flush and load new PC
- redirect_pc  in  PC_WIDTH  redirect target
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_inst  out  INST_WIDTH  head instruction
- out_pc  out  PC_WIDTH  head PC
- out_fault  out  1  head is a misaligned-fetch fault
- perf_fetch_cnt  out  32  instructions pushed (FETCH_PERF_EN only)
- perf_stall_cnt  out  32  cycles fetch blocked by full FIFO (FETCH_PERF_EN only)

## Operation
- States: RUN, HALT. Reset → RUN, pc = RESET_PC, FIFO empty.
- pop = out_valid & out_ready. can_push = (count < FIFO_DEPTH) | pop.
- RUN, no redirect, can_push, pc[1:0]==0: push {pc, imem_inst, 0}; pc += 4 (mod 2^PC_WIDTH, wraps silently).
- RUN, no redirect, can_push, pc[1:0]!=0: push {pc, NOP_INST, 1}; pc holds; → HALT.
- RUN, !can_push: no push, pc holds; stall counted.
- HALT: no push, pc holds; only redirect leaves HALT.
- redirect_valid (any state): FIFO flushed (count=0), pc = redirect_pc, → RUN; no push that cycle; a simultaneous pop is discarded along with the flush.
- Head outputs driven from FIFO head entry; out_inst/out_pc/out_fault are don't-care when out_valid=0, but must be stable while out_valid=1 & out_ready=0.
- Simultaneous push and pop when full: both occur, count unchanged.

## Timing
- Reset values: imem_pc=RESET_PC, out_valid=0, out_inst=0, out_pc=0, out_fault=0, perf counters=0, state=RUN.
- Fetch-to-decode latency: 1 cycle (word captured at edge N, out_valid=1 after edge N).
- After rst deasserts, first edge pushes RESET_PC entry; out_valid high after that edge.
- Redirect at edge N: out_valid=0 after N; target instruction valid after N+1.
- Sustained throughput 1 inst/cycle with out_ready held high.
- rst asserted mid-operation: all state clears immediately (asynchronous), no partial push.
- imem_pc changes only at clock edges (registered).

## Configuration
- FETCH_PERF_EN defined: perf_fetch_cnt increments on each push (including fault push); perf_stall_cnt increments each RUN cycle with !can_push and no redirect; both 32-bit, wrap at 2^32, cleared by rst.
- Not defined: both ports and counters absent; no other behaviour changes.

## Test plan
- Reset, out_ready=1, memory word k = k: out_pc sequence 0,4,8,…, out_inst 0,1,2,… one per cycle from first cycle after reset release.
- out_ready=0 for 5 cycles after start: exactly 2 entries buffered, imem_pc stuck at 8, heads held stable; release → pcs 0,4,8 in order, no loss/duplicate; perf_stall_cnt=3 (with FETCH_PERF_EN).
- redirect_valid with redirect_pc=0x100 while FIFO full: next cycle out_valid=0; following cycle out_pc=0x100.
- redirect_pc=0x102: one entry out_pc=0x102, out_fault=1, out_inst=0x00000013; thereafter no new entries, imem_pc stays 0x102 until redirect to 0x200, which then fetches normally.
- pc=0xFFFF_FFFC: next fetch pc wraps to 0x0000_0000.
- Assert rst asynchronously while out_valid=1 mid-stream: outputs go to reset values before the next edge; fetch resumes at RESET_PC.
